// File: rtl/keyspace_gen.sv
`default_nettype none
// ============================================================================
// keyspace_gen : enumerates one partition of a fixed-prefix character keyspace
// Revision     : 1.0
// ============================================================================
module keyspace_gen #(
  parameter int                            KEY_BITS = 128,
  parameter int                            N_CHARS  = 6,
  parameter logic [7:0]                    CHAR_LO  = 8'h41,
  parameter logic [7:0]                    CHAR_HI  = 8'h7A,
  parameter logic [KEY_BITS-8*N_CHARS-1:0] PREFIX   = 80'h68756c6b206973207468,
  parameter int                            INDEX    = 0,
  parameter int                            TOTAL    = 1,
  parameter int                            CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic [KEY_BITS-1:0] key,
  output logic                key_valid,
  input  logic                key_ready,
  output logic                done,
  output logic [CNT_W-1:0]    keys_issued
);

  localparam int R  = int'(CHAR_HI) - int'(CHAR_LO) + 1;
  localparam int DW = 8 * N_CHARS;

  // INDEX expressed as mixed-radix digits, evaluated at elaboration.
  function automatic logic [DW-1:0] index_digits();
    logic [63:0]   v;
    logic [DW-1:0] d;
    v = 64'(INDEX);
    d = '0;
    for (int i = 0; i < N_CHARS; i++) begin
      d[i*8 +: 8] = CHAR_LO + 8'(v % 64'(R));
      v           = v / 64'(R);
    end
    return d;
  endfunction

  function automatic logic partition_empty();
    logic [63:0] v;
    v = 64'(INDEX);
    for (int i = 0; i < N_CHARS; i++) begin
      v = v / 64'(R);
    end
    return (INDEX >= TOTAL) || (v != 64'd0);
  endfunction

  // Adds TOTAL (<= R, so at most one carry) to d[0] and ripples the carry up.
  // Bit DW of the result is the carry out of the top digit.
  function automatic logic [DW:0] advance(input logic [DW-1:0] d);
    logic [DW-1:0] n;
    logic [8:0]    off;
    logic          c;
    n   = d;
    off = {1'b0, d[7:0]} - {1'b0, CHAR_LO} + 9'(TOTAL);
    if (off >= 9'(R)) begin
      n[7:0] = 8'(off - 9'(R)) + CHAR_LO;
      c      = 1'b1;
    end else begin
      n[7:0] = 8'(off) + CHAR_LO;
      c      = 1'b0;
    end
    for (int i = 1; i < N_CHARS; i++) begin
      if (c) begin
        if (d[i*8 +: 8] == CHAR_HI) begin
          n[i*8 +: 8] = CHAR_LO;
        end else begin
          n[i*8 +: 8] = d[i*8 +: 8] + 8'd1;
          c           = 1'b0;
        end
      end
    end
    return {c, n};
  endfunction

  localparam logic [DW-1:0] INIT_DIGITS = index_digits();
  localparam logic          EMPTY       = partition_empty();

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     digits_q, digits_d;
  logic [CNT_W-1:0]  keys_issued_q, keys_issued_d;
  logic [DW:0]       adv;
  logic              xfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      digits_q      <= {N_CHARS{CHAR_LO}};
      keys_issued_q <= '0;
    end else begin
      state_q       <= state_d;
      digits_q      <= digits_d;
      keys_issued_q <= keys_issued_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    digits_d      = digits_q;
    keys_issued_d = keys_issued_q;
    adv           = advance(digits_q);
    xfer          = (state_q == S_RUN) && key_ready;

    // A wrapped value is never loaded, so the last real key stays on the bus.
    if (xfer) begin
      keys_issued_d = keys_issued_q + CNT_W'(1);
      if (adv[DW]) begin
        state_d = S_DONE;
      end else begin
        digits_d = adv[DW-1:0];
      end
    end

    if (abort) begin
      if (state_q != S_IDLE) begin
        state_d = S_IDLE;
      end
    end else if (start && (state_q != S_RUN)) begin
      digits_d      = INIT_DIGITS;
      keys_issued_d = '0;
      state_d       = EMPTY ? S_DONE : S_RUN;
    end
  end

  assign key         = {PREFIX, digits_q};
  assign key_valid   = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign keys_issued = keys_issued_q;

endmodule
`default_nettype wire

// File: tb/tb_keyspace_gen.sv
`default_nettype none
// ============================================================================
// tb_keyspace_gen : directed checks of keyspace_gen in three configurations
// Revision        : 1.0
// ============================================================================
module tb_keyspace_gen;

  logic clk;
  logic rst;
  logic start;
  logic abort;
  logic key_ready;

  logic [31:0]  key_s;
  logic         valid_s, done_s;
  logic [7:0]   cnt_s;
  logic [31:0]  key_e;
  logic         valid_e, done_e;
  logic [7:0]   cnt_e;
  logic [127:0] key_d;
  logic         valid_d, done_d;
  logic [31:0]  cnt_d;

  int checks = 0;
  int errors = 0;
  logic seen_valid_e = 1'b0;

  localparam logic [79:0] DEF_PREFIX = 80'h68756c6b206973207468;

  keyspace_gen #(
    .KEY_BITS(32), .N_CHARS(2), .CHAR_LO(8'h41), .CHAR_HI(8'h43),
    .PREFIX(16'hBEEF), .INDEX(1), .TOTAL(2), .CNT_W(8)
  ) u_sweep (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .key(key_s), .key_valid(valid_s), .key_ready(key_ready),
    .done(done_s), .keys_issued(cnt_s)
  );

  keyspace_gen #(
    .KEY_BITS(32), .N_CHARS(2), .CHAR_LO(8'h41), .CHAR_HI(8'h43),
    .PREFIX(16'hBEEF), .INDEX(2), .TOTAL(2), .CNT_W(8)
  ) u_empty (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .key(key_e), .key_valid(valid_e), .key_ready(key_ready),
    .done(done_e), .keys_issued(cnt_e)
  );

  keyspace_gen u_dflt (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .key(key_d), .key_valid(valid_d), .key_ready(key_ready),
    .done(done_d), .keys_issued(cnt_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (valid_e) seen_valid_e <= 1'b1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; key_ready = 1'b0;
    #3;
    check("rst_valid", 128'(valid_s), 128'd0);
    check("rst_done", 128'(done_s), 128'd0);
    check("rst_cnt", 128'(cnt_s), 128'd0);
    check("rst_key", 128'(key_s), 128'h BEEF4141);
    check("rst_dkey", key_d, {DEF_PREFIX, 48'h414141414141});
    tick(); tick();
    rst = 1'b0;
    tick();

    // Full sweep at key_ready=1, defaults and empty partition alongside.
    key_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    check("sw_k0", 128'(key_s), 128'h BEEF4142);
    check("sw_v0", 128'(valid_s), 128'd1);
    check("dflt_k0", key_d, {DEF_PREFIX, 48'h414141414141});
    check("empty_done", 128'(done_e), 128'd1);
    check("empty_cnt", 128'(cnt_e), 128'd0);
    tick();
    check("sw_k1", 128'(key_s[15:0]), 128'h4241);
    check("dflt_k1", key_d, {DEF_PREFIX, 48'h414141414142});
    tick();
    check("sw_k2", 128'(key_s[15:0]), 128'h4243);
    tick();
    check("sw_k3", 128'(key_s[15:0]), 128'h4342);
    check("sw_v3", 128'(valid_s), 128'd1);
    tick();
    check("sw_done", 128'(done_s), 128'd1);
    check("sw_vdone", 128'(valid_s), 128'd0);
    check("sw_cnt", 128'(cnt_s), 128'd4);
    tick();
    check("sw_done_hold", 128'(done_s), 128'd1);

    // Restart from DONE with backpressure on the first key.
    key_ready = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    check("restart_done", 128'(done_s), 128'd0);
    for (int i = 0; i < 3; i++) begin
      check("bp_key", 128'(key_s[15:0]), 128'h4142);
      check("bp_valid", 128'(valid_s), 128'd1);
      check("bp_cnt", 128'(cnt_s), 128'd0);
      tick();
    end
    key_ready = 1'b1;
    tick();
    check("bp_k1", 128'(key_s[15:0]), 128'h4241);
    check("bp_cnt1", 128'(cnt_s), 128'd1);
    tick();
    check("bp_cnt2", 128'(cnt_s), 128'd2);

    // Abort after two transfers, with no transfer in the abort cycle.
    key_ready = 1'b0; abort = 1'b1;
    tick(); abort = 1'b0;
    check("ab_valid", 128'(valid_s), 128'd0);
    check("ab_done", 128'(done_s), 128'd0);
    check("ab_cnt", 128'(cnt_s), 128'd2);

    // Abort beats start in IDLE.
    start = 1'b1; abort = 1'b1;
    tick(); start = 1'b0; abort = 1'b0;
    check("ab_prio", 128'(valid_s), 128'd0);

    key_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    check("re_key", 128'(key_s[15:0]), 128'h4142);
    check("re_cnt", 128'(cnt_s), 128'd0);

    // Abort coinciding with a transfer still counts it.
    abort = 1'b1;
    tick(); abort = 1'b0;
    check("abx_cnt", 128'(cnt_s), 128'd1);
    check("abx_valid", 128'(valid_s), 128'd0);

    // Asynchronous reset mid-run.
    key_ready = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    check("pre_rst_v", 128'(valid_s), 128'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 128'(valid_s), 128'd0);
    check("arst_done", 128'(done_s), 128'd0);
    check("arst_cnt", 128'(cnt_s), 128'd0);
    start = 1'b1;
    tick(); tick();
    check("rst_start_ign", 128'(valid_s), 128'd0);
    start = 1'b0; rst = 1'b0;
    tick();
    check("post_rst_idle", 128'(valid_s), 128'd0);
    start = 1'b1;
    tick(); start = 1'b0;
    check("post_rst_key", 128'(key_s[15:0]), 128'h4142);
    check("post_rst_v", 128'(valid_s), 128'd1);

    check("empty_never_valid", 128'(seen_valid_e), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
